// File: rtl/uart_rx2_if.sv
// uart_rx2_if: serial line input and received-byte outputs of the uart_rx2 receiver.
// master = line driver / byte consumer side, slave = the receiver itself.
interface uart_rx2_if;
  logic       RX_DATA;
  logic       RX_DV;
  logic [7:0] RX_BYTE;
  logic       FRAME_ERR;
  logic       PARITY_ERR;
  logic       BUSY;

  modport master (
    output RX_DATA,
    input  RX_DV,
    input  RX_BYTE,
    input  FRAME_ERR,
    input  PARITY_ERR,
    input  BUSY
  );

  modport slave (
    input  RX_DATA,
    output RX_DV,
    output RX_BYTE,
    output FRAME_ERR,
    output PARITY_ERR,
    output BUSY
  );
endinterface

// File: rtl/uart_rx2.sv
// uart_rx2: 8N1 UART receiver, LSB first, idle-high line, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop (8E1).
module uart_rx2 #(
  parameter int F_CLK     = 12_000_000,
  parameter int UART_BAUD = 9600
) (
  input  logic      CLK,
  input  logic      RST_N,
  uart_rx2_if.slave bus
);

  // CLKS_PER_BIT must be at least 4 for the half-bit alignment to make sense.
  localparam int          CLKS_PER_BIT = F_CLK / UART_BAUD;
  localparam int          HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [31:0] BIT_LAST     = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_LAST    = 32'(HALF_BIT);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic        sync1;
  logic        rx_s;
  logic [31:0] cnt;
  logic [31:0] cnt_nxt;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  logic [7:0]  shift;
  logic [7:0]  rx_byte;
  logic        rx_dv;
  logic        frame_err;
  logic        sample_data;
  logic        stop_decide;
  logic        parity_bad;
  logic        byte_ok;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.RX_DATA;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic sample_par;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    sample_data = 1'b0;
    stop_decide = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end
      // A start bit still low at its mid-point is real; otherwise it was a glitch.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          sample_data = 1'b1;
          if (idx == 3'd7) begin
            idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt    = '0;
          sample_par = 1'b1;
          state_nxt  = STOP;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          stop_decide = 1'b1;
          state_nxt   = CLEANUP;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      // Holds through a break or stuck-low line so no repeated frames are produced.
      CLEANUP: begin
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic parity_err;

  assign parity_bad = (^shift) ^ par_bit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (sample_par) begin
        par_bit <= rx_s;
      end
      parity_err <= stop_decide & parity_bad;
    end
  end

  assign bus.PARITY_ERR = parity_err;
`else
  assign parity_bad     = 1'b0;
  assign bus.PARITY_ERR = 1'b0;
`endif

  assign byte_ok = stop_decide & rx_s & ~parity_bad;

  // Strobes are registered so they appear the cycle after the stop-bit decision.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_byte   <= '0;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      if (sample_data) begin
        shift[idx] <= rx_s;
      end
      rx_dv     <= byte_ok;
      frame_err <= stop_decide & ~rx_s;
      if (byte_ok) begin
        rx_byte <= shift;
      end
    end
  end

  assign bus.RX_DV     = rx_dv;
  assign bus.RX_BYTE   = rx_byte;
  assign bus.FRAME_ERR = frame_err;
  assign bus.BUSY      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx2.sv
// tb_uart_rx2: directed plus randomized frames against a frame-level model of uart_rx2.
// Build with UART_RX_PARITY_EN defined to also exercise the parity variant.
module tb_uart_rx2;

  localparam int CPB  = 13;
  localparam int BAUD = 9600;
  localparam int FCLK = CPB * BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx2_if bus();

  uart_rx2 #(
    .F_CLK     (FCLK),
    .UART_BAUD (BAUD)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int         dv_seen = 0;
  int         fe_seen = 0;
  int         pe_seen = 0;
  int         overlap = 0;
  logic [7:0] dv_q[$];

  // Frame-level model: what each transmitted frame should produce.
  logic [7:0] exp_q[$];
  int         exp_fe    = 0;
  int         exp_pe    = 0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.RX_DV) begin
        dv_seen++;
        dv_q.push_back(bus.RX_BYTE);
      end
      if (bus.FRAME_ERR)  fe_seen++;
      if (bus.PARITY_ERR) pe_seen++;
      if (bus.RX_DV && bus.FRAME_ERR) overlap++;
    end
  end

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.RX_DATA = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_clks(input int n);
    bus.RX_DATA = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    logic par_ok;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (PAR_EN) drive_bit(par_bit);
    drive_bit(stop_bit);
    par_ok = !PAR_EN || (((^data) ^ par_bit) == 1'b0);
    if (stop_bit && par_ok) begin
      exp_q.push_back(data);
      last_good = data;
    end
    if (!stop_bit) exp_fe++;
    if (!par_ok)   exp_pe++;
  endtask

  task automatic check_output(input string tag);
    check({tag, ".dv_count"}, 32'(dv_q.size()), 32'(exp_q.size()));
    while (dv_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, ".byte"}, 32'(dv_q.pop_front()), 32'(exp_q.pop_front()));
    end
    dv_q.delete();
    exp_q.delete();
    check({tag, ".frame_err"},  32'(fe_seen), 32'(exp_fe));
    check({tag, ".parity_err"}, 32'(pe_seen), 32'(exp_pe));
    check({tag, ".rx_byte"},    32'(bus.RX_BYTE), 32'(last_good));
    check({tag, ".busy"},       32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop_bit;
    logic       par_bit;
    int         extra_low;

    bus.RX_DATA = 1'b1;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.rx_byte",    32'(bus.RX_BYTE),    32'd0);
    check("reset.rx_dv",      32'(bus.RX_DV),      32'd0);
    check("reset.frame_err",  32'(bus.FRAME_ERR),  32'd0);
    check("reset.parity_err", 32'(bus.PARITY_ERR), 32'd0);
    check("reset.busy",       32'(bus.BUSY),       32'd0);
    rst_n = 1'b1;
    idle_clks(5);

    apply_stimulus(8'hA5, 1'b1, ^8'hA5);
    idle_clks(4);
    check_output("single_a5");

    apply_stimulus(8'h00, 1'b1, 1'b0);
    apply_stimulus(8'hFF, 1'b1, 1'b0);
    apply_stimulus(8'h3C, 1'b1, 1'b0);
    idle_clks(4);
    check_output("back_to_back");

    bus.RX_DATA = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_clks(3 * CPB);
    check_output("glitch");

    apply_stimulus(8'h5A, 1'b0, ^8'h5A);
    drive_bit(1'b0);
    drive_bit(1'b0);
    idle_clks(4);
    check_output("frame_err");
    apply_stimulus(8'h11, 1'b1, ^8'h11);
    idle_clks(4);
    check_output("after_frame_err");

    d = 8'h6B;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.RX_DATA = d[4];
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset.rx_byte", 32'(bus.RX_BYTE), 32'd0);
    check("midreset.rx_dv",   32'(bus.RX_DV),   32'd0);
    check("midreset.busy",    32'(bus.BUSY),    32'd0);
    last_good = 8'h00;
    idle_clks(10);
    rst_n = 1'b1;
    idle_clks(2 * CPB);
    check_output("mid_reset");
    apply_stimulus(8'h81, 1'b1, ^8'h81);
    idle_clks(4);
    check_output("after_reset");

    if (PAR_EN) begin
      apply_stimulus(8'h07, 1'b1, 1'b1);
      idle_clks(4);
      check_output("parity_good");
      apply_stimulus(8'h07, 1'b1, 1'b0);
      idle_clks(4);
      check_output("parity_bad");
    end

    for (int n = 0; n < 10; n++) begin
      d         = 8'($urandom);
      stop_bit  = ($urandom_range(0, 3) != 0);
      par_bit   = (^d) ^ ($urandom_range(0, 3) == 0);
      extra_low = stop_bit ? 0 : int'($urandom_range(0, 2));
      apply_stimulus(d, stop_bit, par_bit);
      for (int k = 0; k < extra_low; k++) drive_bit(1'b0);
      idle_clks(4);
      check_output("random");
      idle_clks(int'($urandom_range(0, 2 * CPB)));
    end

    check("dv_fe_overlap", 32'(overlap), 32'd0);
    check("dv_total", 32'(dv_seen), 32'(dv_seen - 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx2.md
Name: uart_rx2

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx2 transmitter.
- Samples an asynchronous serial line: 8N1, LSB first, idle high.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin and the uart_mirror loopback logic; RX_DV/RX_BYTE feed uart_tx2's TX_DV/TX_BYTE directly.

Parameters:
- F_CLK, 12_000_000, system clock frequency in Hz.
- UART_BAUD, 9600, line baud rate.
- CLKS_PER_BIT, F_CLK / UART_BAUD, clocks per bit period; must be >= 4.
- HALF_BIT, (CLKS_PER_BIT - 1) / 2, clocks from start-edge detect to start-bit mid-sample.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RX_DATA  input  1  raw serial line; asynchronous to CLK.
- RX_DV  output  1  one-cycle pulse; RX_BYTE holds a new valid byte.
- RX_BYTE  output  8  last correctly framed byte; held until the next valid frame.
- FRAME_ERR  output  1  one-cycle pulse; stop bit sampled low.
- PARITY_ERR  output  1  one-cycle pulse; parity mismatch (feature only, else constant 0).
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE; RX_BYTE = 0; RX_DV, FRAME_ERR, PARITY_ERR, BUSY = 0.
  - Bit index and clock counter = 0; shift register = 0.
  - Both synchronizer flops = 1 (idle line).
  - Reset mid-frame aborts the frame with no strobe.
- Input sync: 2-FF synchronizer on RX_DATA; all FSM logic uses the synchronized value rx_s. Line-to-rx_s latency is 2 clocks.
- Clock counter: 32 bit; counts 0..limit-1, then resets to 0 on a state transition or bit advance.
- IDLE:
  - BUSY = 0; counter = 0.
  - rx_s == 0 -> START.
- START:
  - Count to HALF_BIT.
  - At HALF_BIT: rx_s == 0 -> DATA (counter = 0, index = 0).
  - At HALF_BIT: rx_s == 1 -> glitch; back to IDLE with no strobe.
- DATA:
  - Wait CLKS_PER_BIT-1 clocks, then sample rx_s into shift[index] (bit mid-point).
  - Index 0..7. After index 7 -> STOP, or PARITY if the feature is enabled.
- STOP:
  - Wait CLKS_PER_BIT-1 clocks, then sample rx_s.
  - rx_s == 1 (and no parity error): RX_BYTE <= shift and RX_DV = 1 on the next cycle, for exactly one clock.
  - rx_s == 0: FRAME_ERR = 1 for one clock; RX_BYTE unchanged.
  - Then -> CLEANUP.
- CLEANUP:
  - Stay until rx_s == 1, then IDLE.
  - Break or stuck-low line is held here; no repeated frames or errors are generated.
- Strobe rules:
  - RX_DV and FRAME_ERR are never high in the same cycle.
  - No strobe is issued except at the stop-bit decision.
- Back-to-back frames: a start bit arriving one bit period after the stop-bit mid-point is accepted. CLEANUP exits as soon as rx_s is high, so there is no dead time.
- No receive backpressure: the consumer must take RX_BYTE within one frame time.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP.
  - Waits CLKS_PER_BIT-1 clocks, then samples the parity bit; even parity (XOR of 8 data bits ^ parity bit must be 0).
  - Mismatch: PARITY_ERR pulses one clock at the stop-bit decision and RX_DV is suppressed.
  - If the stop bit is also bad, FRAME_ERR and PARITY_ERR pulse together.
  - Frame length is 11 bits.
- Not defined: no PARITY state; PARITY_ERR tied 0; 8N1 only.

Test Plan:
- Reset then idle line, CLKS_PER_BIT=13: send 0xA5 at 13 clk/bit -> one RX_DV pulse, RX_BYTE=0xA5, FRAME_ERR=0, BUSY low again after stop.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap -> three RX_DV pulses in order with matching RX_BYTE, no errors.
- Start-bit glitch, line low for 4 clocks (< HALF_BIT=6) -> returns to IDLE, no RX_DV, RX_BYTE unchanged.
- Frame 0x5A with stop bit forced low, line returning high 3 bit periods later:
  - FRAME_ERR one pulse; RX_BYTE keeps its prior value.
  - The next 0x11 frame is received correctly.
- RST_N asserted during bit 4 of a frame -> outputs zero immediately, no strobe; the following frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> RX_DV and 0x07; 0x07 with parity 0 -> PARITY_ERR pulse, no RX_DV.
